// File: rtl/data_mem_ctrl.sv
// Byte-addressable data memory for the RV32 load/store path: valid/ready request/response,
// byte-lane write masking, alignment/range checks and optional two-beat misaligned access.
module data_mem_ctrl #(
    parameter int unsigned DEPTH_BYTES    = 1024,
    parameter bit          MISALIGN_SPLIT = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic        req_we_i,
    input  logic [2:0]  req_funct3_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);

    localparam int unsigned Words = DEPTH_BYTES / 4;
    localparam int unsigned Aw    = (Words > 1) ? $clog2(Words) : 1;

    typedef enum logic [1:0] {StIdle, StSplit, StResp} state_e;

    state_e state_q, state_d;

    logic [31:0]   mem_q [Words];

    logic [2:0]    f3_q, f3_d;
    logic [1:0]    off_q, off_d;
    logic          we_q, we_d;
    logic [Aw-1:0] hi_idx_q, hi_idx_d;
    logic [3:0]    be_hi_q, be_hi_d;
    logic [31:0]   data_hi_q, data_hi_d;
    logic [31:0]   lo_q, lo_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    logic [2:0]    size;
    logic [3:0]    size_mask;
    logic          bad_f3;
    logic          store_bad;
    logic [32:0]   last_addr;
    logic          out_of_range;
    logic          misaligned;
    logic          acc_err;
    logic          acc_split;
    logic          accept;
    logic [1:0]    off;
    logic [Aw-1:0] req_idx;
    logic [7:0]    mask64;
    logic [63:0]   data64;
    logic [31:0]   rd_lo;
    logic [31:0]   rd_hi;
    logic [31:0]   lo_raw;
    logic [31:0]   split_raw;

    logic          wr_en;
    logic [Aw-1:0] wr_idx;
    logic [3:0]    wr_be;
    logic [31:0]   wr_data;

    function automatic logic [31:0] load_ext(input logic [31:0] raw, input logic [2:0] f3);
        logic [31:0] res;
        case (f3)
            3'b000:  res = {{24{raw[7]}}, raw[7:0]};
            3'b001:  res = {{16{raw[15]}}, raw[15:0]};
            3'b100:  res = {24'b0, raw[7:0]};
            3'b101:  res = {16'b0, raw[15:0]};
            default: res = raw;
        endcase
        return res;
    endfunction

    // Request decode: size, legality, range and alignment
    always_comb begin
        size   = 3'd4;
        bad_f3 = 1'b0;
        case (req_funct3_i)
            3'b000, 3'b100: size = 3'd1;
            3'b001, 3'b101: size = 3'd2;
            3'b010:         size = 3'd4;
            default:        bad_f3 = 1'b1;
        endcase
    end

    assign size_mask    = (size == 3'd1) ? 4'b0001 : ((size == 3'd2) ? 4'b0011 : 4'b1111);
    assign store_bad    = req_we_i & req_funct3_i[2];
    assign last_addr    = {1'b0, req_addr_i} + {30'b0, size} - 33'd1;
    assign out_of_range = last_addr >= 33'(DEPTH_BYTES);
    assign misaligned   = ((size == 3'd2) & req_addr_i[0]) |
                          ((size == 3'd4) & (req_addr_i[1:0] != 2'b00));
    assign acc_err      = bad_f3 | store_bad | out_of_range | (misaligned & !MISALIGN_SPLIT);
    assign acc_split    = misaligned & !acc_err;

    assign req_ready_o  = (state_q == StIdle) & !rst_i;
    assign accept       = req_valid_i & req_ready_o;

    // Lanes and data placed on a two-word window; the upper word is only used by a split beat
    assign off     = req_addr_i[1:0];
    assign req_idx = req_addr_i[Aw+1:2];
    assign mask64  = {4'b0, size_mask} << off;
    assign data64  = {32'b0, req_wdata_i} << {off, 3'b000};

    assign rd_lo     = mem_q[req_idx];
    assign rd_hi     = mem_q[hi_idx_q];
    assign lo_raw    = rd_lo >> {off, 3'b000};
    assign split_raw = 32'({rd_hi, lo_q} >> {off_q, 3'b000});

    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = req_idx;
        wr_be   = mask64[3:0];
        wr_data = data64[31:0];
        if (state_q == StIdle) begin
            wr_en = accept & req_we_i & !acc_err;
        end else if (state_q == StSplit) begin
            // Second beat is dropped if reset arrives mid-split
            wr_en   = we_q & !rst_i;
            wr_idx  = hi_idx_q;
            wr_be   = be_hi_q;
            wr_data = data_hi_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) begin
                    mem_q[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        f3_d      = f3_q;
        off_d     = off_q;
        we_d      = we_q;
        hi_idx_d  = hi_idx_q;
        be_hi_d   = be_hi_q;
        data_hi_d = data_hi_q;
        lo_d      = lo_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    f3_d      = req_funct3_i;
                    off_d     = off;
                    we_d      = req_we_i;
                    hi_idx_d  = req_idx + Aw'(1);
                    be_hi_d   = mask64[7:4];
                    data_hi_d = data64[63:32];
                    lo_d      = rd_lo;
                    if (acc_split) begin
                        state_d = StSplit;
                        rdata_d = 32'b0;
                        err_d   = 1'b0;
                    end else begin
                        state_d = StResp;
                        err_d   = acc_err;
                        rdata_d = (acc_err | req_we_i) ? 32'b0 : load_ext(lo_raw, req_funct3_i);
                    end
                end
            end
            StSplit: begin
                state_d = StResp;
                err_d   = 1'b0;
                rdata_d = we_q ? 32'b0 : load_ext(split_raw, f3_q);
            end
            StResp: begin
                if (rsp_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            rdata_q <= 32'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk_i) begin
        f3_q      <= f3_d;
        off_q     <= off_d;
        we_q      <= we_d;
        hi_idx_q  <= hi_idx_d;
        be_hi_q   <= be_hi_d;
        data_hi_q <= data_hi_d;
        lo_q      <= lo_d;
    end

    assign rsp_valid_o = (state_q == StResp);
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: two instances (no split / split) against a byte-array model,
// with directed scenarios pinned by literal values and a randomized load/store mix.
module tb_data_mem_ctrl;

    localparam int unsigned Depth = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic        req_we     [2];
    logic [2:0]  req_funct3 [2];
    logic        rsp_valid  [2];
    logic        rsp_ready  [2];
    logic [31:0] rsp_rdata  [2];
    logic        rsp_err    [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        data_mem_ctrl #(
            .DEPTH_BYTES   (Depth),
            .MISALIGN_SPLIT(g == 1)
        ) u_dut (
            .clk_i       (clk),
            .rst_i       (rst),
            .req_valid_i (req_valid[g]),
            .req_ready_o (req_ready[g]),
            .req_addr_i  (req_addr[g]),
            .req_wdata_i (req_wdata[g]),
            .req_we_i    (req_we[g]),
            .req_funct3_i(req_funct3[g]),
            .rsp_valid_o (rsp_valid[g]),
            .rsp_ready_i (rsp_ready[g]),
            .rsp_rdata_o (rsp_rdata[g]),
            .rsp_err_o   (rsp_err[g])
        );
    end

    int errors = 0;
    int checks = 0;

    logic [7:0]  mem_m [2][Depth];
    logic [31:0] exp_rdata [2];
    logic        exp_err   [2];
    bit          chk_en = 1'b0;

    bit          hold_prev [2];
    logic [31:0] rdata_prev [2];
    logic        err_prev   [2];
    logic        rst_prev;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: bytes in a flat array, every rule computed directly.
    task automatic model_access(input int k, input logic we, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output logic err, output logic [31:0] rd, output bit split);
        int     size;
        bit     illegal;
        longint last;
        bit     mis;
        logic [31:0] raw;
        illegal = 1'b0;
        case (f3)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            3'd2:       size = 4;
            default: begin size = 4; illegal = 1'b1; end
        endcase
        if (we && f3 >= 3'd4) illegal = 1'b1;
        last  = longint'({32'b0, addr}) + longint'(size) - 1;
        mis   = (addr % size) != 0;
        err   = illegal || (last >= longint'(Depth)) || (mis && k == 0);
        split = !err && mis;
        rd    = 32'b0;
        if (!err) begin
            if (we) begin
                for (int i = 0; i < size; i++) mem_m[k][int'(addr) + i] = wdata[8*i +: 8];
            end else begin
                raw = 32'b0;
                for (int i = 0; i < size; i++) raw[8*i +: 8] = mem_m[k][int'(addr) + i];
                if (f3 == 3'd0)      rd = 32'($signed(raw[7:0]));
                else if (f3 == 3'd1) rd = 32'($signed(raw[15:0]));
                else                 rd = raw;
            end
        end
    endtask

    // Full transaction: model first, then drive, measure latency, hold, consume.
    task automatic do_req(input int k, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                          output logic [31:0] rd, output logic er);
        logic [31:0] r;
        logic        e;
        bit          sp;
        int          n;
        model_access(k, we, f3, addr, wdata, e, r, sp);
        @(posedge clk); #1;
        req_valid[k]  = 1'b1;
        req_we[k]     = we;
        req_funct3[k] = f3;
        req_addr[k]   = addr;
        req_wdata[k]  = wdata;
        n = 0;
        while (!req_ready[k] && n < 20) begin @(posedge clk); #1; n++; end
        check32("req_ready_wait", {31'b0, req_ready[k]}, 32'd1);
        exp_rdata[k] = r;
        exp_err[k]   = e;
        @(posedge clk); #1;
        req_valid[k]  = 1'b0;
        req_addr[k]   = $urandom;
        req_wdata[k]  = $urandom;
        req_we[k]     = 1'($urandom);
        req_funct3[k] = 3'($urandom);
        n = 1;
        while (!rsp_valid[k] && n < 10) begin @(posedge clk); #1; n++; end
        check32("rsp_latency", n, sp ? 32'd2 : 32'd1);
        repeat (hold) begin
            @(posedge clk); #1;
            check32("hold_req_ready", {31'b0, req_ready[k]}, 32'd0);
        end
        rd = rsp_rdata[k];
        er = rsp_err[k];
        rsp_ready[k] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[k] = 1'b0;
        check32("post_consume_valid", {31'b0, rsp_valid[k]}, 32'd0);
        check32("post_consume_ready", {31'b0, req_ready[k]}, 32'd1);
    endtask

    // Compare process: response contents and hold-stability on every cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                if (rsp_valid[k] === 1'b1) begin
                    check32("rsp_rdata", rsp_rdata[k], exp_rdata[k]);
                    check32("rsp_err", {31'b0, rsp_err[k]}, {31'b0, exp_err[k]});
                    check32("ready_in_resp", {31'b0, req_ready[k]}, 32'd0);
                end
                if (hold_prev[k] && !rst_prev) begin
                    check32("stable_valid", {31'b0, rsp_valid[k]}, 32'd1);
                    check32("stable_rdata", rsp_rdata[k], rdata_prev[k]);
                    check32("stable_err", {31'b0, rsp_err[k]}, {31'b0, err_prev[k]});
                end
                if (rst) check32("ready_in_rst", {31'b0, req_ready[k]}, 32'd0);
                hold_prev[k]  = (rsp_valid[k] === 1'b1) && !rsp_ready[k];
                rdata_prev[k] = rsp_rdata[k];
                err_prev[k]   = rsp_err[k];
            end
            rst_prev = rst;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [31:0] r1, r2;
        logic        e1;
        bit          sp;
        int          n;
        int          k;
        int          mode;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [2:0]  legal_f3 [5];
        legal_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

        rst = 1'b1;
        rst_prev = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0; req_we[i] = 1'b0; req_funct3[i] = 3'd0;
            req_addr[i] = 32'b0; req_wdata[i] = 32'b0; rsp_ready[i] = 1'b0;
            exp_rdata[i] = 32'b0; exp_err[i] = 1'b0; hold_prev[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check32("reset_rsp_valid", {31'b0, rsp_valid[i]}, 32'd0);
            check32("reset_rsp_rdata", rsp_rdata[i], 32'd0);
            check32("reset_rsp_err", {31'b0, rsp_err[i]}, 32'd0);
            check32("reset_req_ready", {31'b0, req_ready[i]}, 32'd0);
        end
        rst = 1'b0;
        #1;
        check32("ready_after_reset", {31'b0, req_ready[0]}, 32'd1);
        chk_en = 1'b1;

        // Zero both memories so the model starts from known contents
        for (int i = 0; i < 2; i++)
            for (int w = 0; w < int'(Depth / 4); w++)
                do_req(i, 1'b1, 3'd2, 32'(w * 4), 32'b0, 0, rd, er);

        // Sign/zero extension
        do_req(0, 1'b1, 3'd2, 32'h10, 32'h800000FF, 0, rd, er);
        check32("t1_sw_err", {31'b0, er}, 32'd0);
        do_req(0, 1'b0, 3'd0, 32'h10, 32'h0, 1, rd, er);
        check32("t1_lb", rd, 32'hFFFFFFFF);
        do_req(0, 1'b0, 3'd4, 32'h10, 32'h0, 0, rd, er);
        check32("t1_lbu", rd, 32'h000000FF);
        do_req(0, 1'b0, 3'd1, 32'h12, 32'h0, 2, rd, er);
        check32("t1_lh", rd, 32'hFFFF8000);
        check32("t1_lh_err", {31'b0, er}, 32'd0);

        // Byte-lane masking
        do_req(0, 1'b1, 3'd2, 32'h20, 32'h11223344, 0, rd, er);
        do_req(0, 1'b1, 3'd0, 32'h21, 32'h000000AA, 0, rd, er);
        do_req(0, 1'b0, 3'd2, 32'h20, 32'h0, 0, rd, er);
        check32("t2_lw_merge", rd, 32'h1122AA44);

        // Misaligned word: split vs error
        do_req(1, 1'b1, 3'd2, 32'h31, 32'hDEADBEEF, 0, rd, er);
        check32("t3_split_sw_err", {31'b0, er}, 32'd0);
        do_req(1, 1'b0, 3'd2, 32'h31, 32'h0, 0, rd, er);
        check32("t3_split_lw31", rd, 32'hDEADBEEF);
        do_req(1, 1'b0, 3'd2, 32'h30, 32'h0, 0, rd, er);
        check32("t3_split_lw30", rd, 32'hADBEEF00);
        do_req(1, 1'b0, 3'd2, 32'h34, 32'h0, 0, rd, er);
        check32("t3_split_lw34", rd, 32'h000000DE);
        do_req(0, 1'b1, 3'd2, 32'h31, 32'hDEADBEEF, 0, rd, er);
        check32("t3_nosplit_err", {31'b0, er}, 32'd1);
        do_req(0, 1'b0, 3'd2, 32'h30, 32'h0, 0, rd, er);
        check32("t3_nosplit_lw30", rd, 32'h0);

        // Range and legality
        do_req(0, 1'b0, 3'd2, 32'h3FC, 32'h0, 0, rd, er);
        check32("t4_lw_last", {31'b0, er}, 32'd0);
        do_req(1, 1'b0, 3'd2, 32'h3FE, 32'h0, 0, rd, er);
        check32("t4_lw_3fe_err", {31'b0, er}, 32'd1);
        check32("t4_lw_3fe_rdata", rd, 32'h0);
        do_req(0, 1'b1, 3'd0, 32'h400, 32'h55, 0, rd, er);
        check32("t4_sb_400_err", {31'b0, er}, 32'd1);
        do_req(0, 1'b0, 3'd0, 32'hFFFFFFFF, 32'h0, 0, rd, er);
        check32("t4_lb_wrap_err", {31'b0, er}, 32'd1);
        do_req(0, 1'b0, 3'd3, 32'h0, 32'h0, 0, rd, er);
        check32("t4_f3_011_err", {31'b0, er}, 32'd1);
        do_req(0, 1'b1, 3'd4, 32'h20, 32'hFFFFFFFF, 0, rd, er);
        check32("t4_store_bu_err", {31'b0, er}, 32'd1);
        do_req(0, 1'b1, 3'd5, 32'h20, 32'hFFFFFFFF, 0, rd, er);
        check32("t4_store_hu_err", {31'b0, er}, 32'd1);
        do_req(0, 1'b0, 3'd2, 32'h20, 32'h0, 0, rd, er);
        check32("t4_no_write_on_err", rd, 32'h1122AA44);

        // Backpressure with a second request waiting
        model_access(0, 1'b0, 3'd2, 32'h20, 32'h0, e1, r1, sp);
        model_access(0, 1'b0, 3'd4, 32'h20, 32'h0, e1, r2, sp);
        check32("t5_model_lbu", r2, 32'h00000044);
        exp_rdata[0] = r1;
        exp_err[0]   = 1'b0;
        @(posedge clk); #1;
        req_valid[0] = 1'b1; req_we[0] = 1'b0; req_funct3[0] = 3'd2; req_addr[0] = 32'h20;
        n = 0;
        while (!req_ready[0] && n < 20) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        req_funct3[0] = 3'd4;
        for (int c = 0; c < 5; c++) begin
            check32("t5_hold_valid", {31'b0, rsp_valid[0]}, 32'd1);
            check32("t5_hold_rdata", rsp_rdata[0], 32'h1122AA44);
            check32("t5_hold_ready", {31'b0, req_ready[0]}, 32'd0);
            @(posedge clk); #1;
        end
        rsp_ready[0] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[0] = 1'b0;
        exp_rdata[0] = r2;
        check32("t5_bubble_valid", {31'b0, rsp_valid[0]}, 32'd0);
        check32("t5_bubble_ready", {31'b0, req_ready[0]}, 32'd1);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        check32("t5_second_valid", {31'b0, rsp_valid[0]}, 32'd1);
        check32("t5_second_rdata", rsp_rdata[0], 32'h00000044);
        rsp_ready[0] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[0] = 1'b0;

        // Reset in the middle of a split store
        do_req(1, 1'b1, 3'd2, 32'h30, 32'h0, 0, rd, er);
        do_req(1, 1'b1, 3'd2, 32'h34, 32'h0, 0, rd, er);
        @(posedge clk); #1;
        req_valid[1] = 1'b1; req_we[1] = 1'b1; req_funct3[1] = 3'd2;
        req_addr[1] = 32'h31; req_wdata[1] = 32'hDEADBEEF;
        n = 0;
        while (!req_ready[1] && n < 20) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        check32("t6_rst_valid", {31'b0, rsp_valid[1]}, 32'd0);
        rst = 1'b0;
        mem_m[1][32'h31] = 8'hEF;
        mem_m[1][32'h32] = 8'hBE;
        mem_m[1][32'h33] = 8'hAD;
        repeat (2) begin
            @(posedge clk); #1;
            check32("t6_no_rsp", {31'b0, rsp_valid[1]}, 32'd0);
        end
        do_req(1, 1'b0, 3'd2, 32'h30, 32'h0, 0, rd, er);
        check32("t6_lw30", rd, 32'hADBEEF00);
        do_req(1, 1'b0, 3'd2, 32'h34, 32'h0, 0, rd, er);
        check32("t6_lw34", rd, 32'h00000000);

        // Randomized mix on both instances
        for (int t = 0; t < 400; t++) begin
            k    = int'($urandom_range(0, 1));
            mode = int'($urandom_range(0, 9));
            if (mode <= 6)      addr = 32'($urandom_range(0, 127));
            else if (mode == 7) addr = 32'(Depth - 8) + 32'($urandom_range(0, 11));
            else if (mode == 8) addr = $urandom;
            else                addr = 32'hFFFFFFF0 + 32'($urandom_range(0, 15));
            if ($urandom_range(0, 9) < 8) f3 = legal_f3[$urandom_range(0, 4)];
            else                          f3 = 3'($urandom_range(0, 7));
            do_req(k, 1'($urandom), f3, addr, $urandom, int'($urandom_range(0, 3)), rd, er);
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
